// File: rtl/data_ram_mmio_pkg.sv
// Shared definitions for the data RAM / MMIO block: MMIO register offsets,
// byte-lane count, address decode classes and the decode helper.
package data_ram_pkg;

  localparam int LANES        = 4;
  localparam int OFF_BTN_RAW  = 0;
  localparam int OFF_BTN_EDGE = 1;
  localparam int OFF_CYCLE    = 2;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_BTN_RAW,
    DEC_BTN_EDGE,
    DEC_CYCLE,
    DEC_NONE
  } dec_e;

  // Classify a 16-bit word index against the RAM depth and the MMIO window.
  function automatic dec_e decode(input logic [15:0] w, input int depth, input int base);
    int wi;
    wi = int'({16'd0, w});
    if (wi < depth)                     return DEC_RAM;
    else if (wi == base + OFF_BTN_RAW)  return DEC_BTN_RAW;
    else if (wi == base + OFF_BTN_EDGE) return DEC_BTN_EDGE;
    else if (wi == base + OFF_CYCLE)    return DEC_CYCLE;
    else                                return DEC_NONE;
  endfunction

endpackage

// File: rtl/data_ram_mmio_if.sv
// CPU load/store bus plus the VGA read port of the data RAM.
// master = requester (CPU side / bench), slave = the RAM block.
interface data_ram_mmio_if;
  logic        en;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        vga_ren;
  logic [31:0] vga_raddr;
  logic [31:0] vga_rdata;

  modport master (
    output en, we, sel, addr, wdata, vga_ren, vga_raddr,
    input  rdata, rvalid, err, vga_rdata
  );

  modport slave (
    input  en, we, sel, addr, wdata, vga_ren, vga_raddr,
    output rdata, rvalid, err, vga_rdata
  );
endinterface

// File: rtl/data_ram_mmio_btn_sync_edge.sv
// Button synchroniser (two flops), rising-edge detector and sticky
// write-one-to-clear edge latch. A new edge beats a clear of the same bit.
module btn_sync_edge #(
  parameter int BTN_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BTN_WIDTH-1:0] i_btn,
  input  logic [BTN_WIDTH-1:0] i_clr,
  output logic [BTN_WIDTH-1:0] o_raw,
  output logic [BTN_WIDTH-1:0] o_edge
);

  logic [BTN_WIDTH-1:0] r_sync1;
  logic [BTN_WIDTH-1:0] r_sync2;
  logic [BTN_WIDTH-1:0] r_edge;
  logic [BTN_WIDTH-1:0] w_rise;

  // Rise is seen as the new level enters r_sync2, so the edge latch and the
  // synchronised level update on the same clock.
  assign w_rise = r_sync1 & ~r_sync2;

  // Synchronise the asynchronous levels and maintain the sticky edge bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_edge  <= (r_edge & ~i_clr) | w_rise;
    end
  end

  assign o_raw  = r_sync2;
  assign o_edge = r_edge;

endmodule

// File: rtl/data_ram_mmio.sv
// Byte-lane data RAM with registered CPU and VGA read ports plus an MMIO
// window (synchronised buttons, sticky button edges, free-running counter).
// Optional: define DATA_RAM_WRITE_FIRST_EN to make a VGA read that collides
// with a CPU write return the merged new word; otherwise it returns the old one.
module data_ram_mmio
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MMIO_BASE  = 1024,
  parameter int BTN_WIDTH  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BTN_WIDTH-1:0] i_btn_in,
  data_ram_mmio_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_err;
  logic [31:0]           r_vga_rdata;
  logic [31:0]           r_cycle;

  logic [ADDR_WIDTH-1:0] w_cpu_idx;
  logic [ADDR_WIDTH-1:0] w_vga_idx;
  dec_e                  w_dec;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_ram_wr;
  logic [31:0]           w_lane_mask;
  logic [31:0]           w_clr32;
  logic [31:0]           w_cycle_next;
  logic [BTN_WIDTH-1:0]  w_btn_raw;
  logic [BTN_WIDTH-1:0]  w_btn_edge;
  logic [31:0]           w_raw32;
  logic [31:0]           w_edge32;
  logic                  w_unused;

  assign w_cpu_idx = bus.addr[ADDR_WIDTH+1:2];
  assign w_vga_idx = bus.vga_raddr[ADDR_WIDTH+1:2];
  assign w_dec     = decode(bus.addr[17:2], DEPTH, MMIO_BASE);
  assign w_rd      = bus.en & ~bus.we;
  assign w_wr      = bus.en & bus.we;
  assign w_ram_wr  = w_wr && (w_dec == DEC_RAM);

  // Expand the byte selects into a 32-bit lane mask.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_mask[gi*8 +: 8] = {8{bus.sel[gi]}};
    end
  endgenerate

  // W1C mask for the edge latch, honouring the byte selects.
  assign w_clr32 = (w_wr && (w_dec == DEC_BTN_EDGE)) ? (bus.wdata & w_lane_mask) : 32'd0;

  btn_sync_edge #(.BTN_WIDTH(BTN_WIDTH)) u_btn (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_btn_in),
    .i_clr  (w_clr32[BTN_WIDTH-1:0]),
    .o_raw  (w_btn_raw),
    .o_edge (w_btn_edge)
  );

  // Zero-extend the button registers to a full bus word.
  always_comb begin
    w_raw32  = '0;
    w_edge32 = '0;
    w_raw32[BTN_WIDTH-1:0]  = w_btn_raw;
    w_edge32[BTN_WIDTH-1:0] = w_btn_edge;
  end

  // Counter value after this edge: full-word writes load it, else it counts.
  assign w_cycle_next = (w_wr && (w_dec == DEC_CYCLE) && (bus.sel == 4'b1111))
                        ? bus.wdata : r_cycle + 32'd1;

  // Free-running cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cycle <= '0;
    else       r_cycle <= w_cycle_next;
  end

  // RAM byte-lane writes; intentionally not gated by reset.
  always_ff @(posedge i_clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.sel[i]) r_mem[w_cpu_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
  end

  // CPU read data, valid strobe and unmapped-access pulse.
  // A CYCLE read returns the count as it stands after this edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= bus.en && (w_dec == DEC_NONE);
      if (w_rd) begin
        case (w_dec)
          DEC_RAM:      r_rdata <= r_mem[w_cpu_idx];
          DEC_BTN_RAW:  r_rdata <= w_raw32;
          DEC_BTN_EDGE: r_rdata <= w_edge32;
          DEC_CYCLE:    r_rdata <= w_cycle_next;
          default:      r_rdata <= '0;
        endcase
      end
    end
  end

  // VGA read port; RAM only, address wraps on the RAM depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vga_rdata <= '0;
    end else if (bus.vga_ren) begin
`ifdef DATA_RAM_WRITE_FIRST_EN
      if (w_ram_wr && (w_cpu_idx == w_vga_idx))
        r_vga_rdata <= (r_mem[w_vga_idx] & ~w_lane_mask) | (bus.wdata & w_lane_mask);
      else
        r_vga_rdata <= r_mem[w_vga_idx];
`else
      r_vga_rdata <= r_mem[w_vga_idx];
`endif
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.rvalid    = r_rvalid;
  assign bus.err       = r_err;
  assign bus.vga_rdata = r_vga_rdata;

  // Address bits that play no part in decode or indexing.
  assign w_unused = ^{bus.addr[31:18], bus.addr[1:0],
                      bus.vga_raddr[31:ADDR_WIDTH+2], bus.vga_raddr[1:0]};

endmodule

// File: tb/tb_data_ram_mmio.sv
// Directed bench for data_ram_mmio: byte lanes, back-to-back reads, buttons,
// cycle counter, unmapped access, VGA wrap, write collision and reset.
module tb_data_ram_mmio;

  localparam logic [31:0] A_BTN_RAW  = 32'h0000_1000;
  localparam logic [31:0] A_BTN_EDGE = 32'h0000_1004;
  localparam logic [31:0] A_CYCLE    = 32'h0000_1008;
  localparam logic [31:0] A_UNMAPPED = 32'h0000_101C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] btn_in;
  int          checks   = 0;
  int          failures = 0;

  data_ram_mmio_if bus ();

  data_ram_mmio #(
    .ADDR_WIDTH (10),
    .MMIO_BASE  (1024),
    .BTN_WIDTH  (32)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_in (btn_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.en      = 1'b0;
    bus.we      = 1'b0;
    bus.vga_ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.sel = s;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = a; bus.sel = 4'b0000;
    tick();
  endtask

  task automatic idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    btn_in = '0;
    bus.en = 1'b0; bus.we = 1'b0; bus.sel = 4'b0; bus.addr = '0; bus.wdata = '0;
    bus.vga_ren = 1'b0; bus.vga_raddr = '0;
    tick(); tick();
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'h0);
    chk("rst_err", {31'd0, bus.err}, 32'h0);
    chk("rst_vga", bus.vga_rdata, 32'h0);
    rst = 1'b0;

    // Counter restarts at 0; the first post-reset read sees 1.
    rd(A_CYCLE);
    chk("cycle_after_rst", bus.rdata, 32'h1);
    rd(A_BTN_EDGE);
    chk("btn_edge_rst", bus.rdata, 32'h0);

    // Byte-lane writes to word 5.
    wr(32'h14, 32'hAABBCCDD, 4'b1111);
    chk("wr_no_rvalid", {31'd0, bus.rvalid}, 32'h0);
    wr(32'h14, 32'h11223344, 4'b0101);
    rd(32'h14);
    chk("byte_lane_rdata", bus.rdata, 32'hAA22CC44);
    chk("byte_lane_rvalid", {31'd0, bus.rvalid}, 32'h1);
    idle();
    chk("rvalid_one_cycle", {31'd0, bus.rvalid}, 32'h0);
    chk("rdata_holds", bus.rdata, 32'hAA22CC44);

    // Back-to-back reads of words 0..2.
    wr(32'h0, 32'h0000_0A00, 4'b1111);
    wr(32'h4, 32'h0000_0A01, 4'b1111);
    wr(32'h8, 32'h0000_0A02, 4'b1111);
    rd(32'h0);
    chk("b2b_0", bus.rdata, 32'h0000_0A00);
    chk("b2b_0_v", {31'd0, bus.rvalid}, 32'h1);
    rd(32'h4);
    chk("b2b_1", bus.rdata, 32'h0000_0A01);
    chk("b2b_1_v", {31'd0, bus.rvalid}, 32'h1);
    rd(32'h8);
    chk("b2b_2", bus.rdata, 32'h0000_0A02);
    chk("b2b_2_v", {31'd0, bus.rvalid}, 32'h1);

    // Buttons: rise on bit 3, W1C, read-only raw, clear coincident with new edge.
    btn_in[3] = 1'b1;
    idle(); idle();
    rd(A_BTN_RAW);
    chk("btn_raw", bus.rdata, 32'h8);
    rd(A_BTN_EDGE);
    chk("btn_edge_set", bus.rdata, 32'h8);
    wr(A_BTN_RAW, 32'h0, 4'b1111);
    rd(A_BTN_RAW);
    chk("btn_raw_ro", bus.rdata, 32'h8);
    wr(A_BTN_EDGE, 32'h8, 4'b1111);
    rd(A_BTN_EDGE);
    chk("btn_edge_w1c", bus.rdata, 32'h0);
    btn_in[3] = 1'b0;
    idle(); idle(); idle();
    btn_in[3] = 1'b1;
    idle();
    wr(A_BTN_EDGE, 32'h8, 4'b1111);
    rd(A_BTN_EDGE);
    chk("btn_set_wins", bus.rdata, 32'h8);

    // Cycle counter load, wrap and partial-write immunity.
    wr(A_CYCLE, 32'hFFFF_FFFE, 4'b1111);
    rd(A_CYCLE);
    chk("cycle_ffffffff", bus.rdata, 32'hFFFF_FFFF);
    rd(A_CYCLE);
    chk("cycle_wrap", bus.rdata, 32'h0);
    wr(A_CYCLE, 32'h0, 4'b0011);
    rd(A_CYCLE);
    chk("cycle_partial_ign", bus.rdata, 32'h2);

    // Unmapped read and write.
    rd(A_UNMAPPED);
    chk("unmap_rdata", bus.rdata, 32'h0);
    chk("unmap_rvalid", {31'd0, bus.rvalid}, 32'h1);
    chk("unmap_err", {31'd0, bus.err}, 32'h1);
    idle();
    chk("unmap_err_pulse", {31'd0, bus.err}, 32'h0);
    wr(A_UNMAPPED, 32'h5555_5555, 4'b1111);
    chk("unmap_wr_err", {31'd0, bus.err}, 32'h1);
    rd(32'h14);
    chk("read_ok_no_err", {31'd0, bus.err}, 32'h0);

    // VGA wrap: byte 0x1014 maps to word 5.
    bus.vga_ren = 1'b1; bus.vga_raddr = 32'h0000_1014;
    idle();
    chk("vga_wrap", bus.vga_rdata, 32'hAA22CC44);
    bus.vga_raddr = 32'h0;
    idle();
    chk("vga_hold", bus.vga_rdata, 32'hAA22CC44);

    // VGA/CPU collision on word 9.
    wr(32'h24, 32'h1234_5678, 4'b1111);
    bus.vga_ren = 1'b1; bus.vga_raddr = 32'h24;
    wr(32'h24, 32'hDEAD_BEEF, 4'b1111);
`ifdef DATA_RAM_WRITE_FIRST_EN
    chk("vga_collision", bus.vga_rdata, 32'hDEAD_BEEF);
`else
    chk("vga_collision", bus.vga_rdata, 32'h1234_5678);
`endif
    bus.vga_ren = 1'b1; bus.vga_raddr = 32'h24;
    idle();
    chk("vga_after_wr", bus.vga_rdata, 32'hDEAD_BEEF);

    // Reset during a read, then a write performed in a reset cycle.
    rd(32'h14);
    rst = 1'b1;
    rd(A_CYCLE);
    chk("rst_mid_rvalid", {31'd0, bus.rvalid}, 32'h0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    rd(A_CYCLE);
    chk("rst_mid_cycle", bus.rdata, 32'h1);
    rst = 1'b1;
    wr(32'h30, 32'hCAFE_F00D, 4'b1111);
    rst = 1'b0;
    rd(32'h30);
    chk("rst_cycle_write", bus.rdata, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram_mmio.md
Name: data_ram_mmio

Overview:
- Parametrised successor of the byte-lane data RAM.
- Provides:
  - a CPU load/store port with per-byte write selects and a registered read (1-cycle latency, rvalid strobe);
  - an independent registered VGA read port;
  - a small MMIO window: synchronised buttons, sticky button-edge latch, free-running cycle counter.
- Sits between MEM stage and VGA controller; replaces combinational-read RAM.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- MMIO_BASE, 1024, word index of first MMIO register; must be >= 2**ADDR_WIDTH.
- BTN_WIDTH, 32, number of button inputs (1..32), zero-extended on read.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  CPU access enable.
- we  in  1  CPU write enable (qualified by en).
- sel  in  4  byte-lane write selects; sel[3] = bits 31:24.
- addr  in  32  CPU byte address; word index = addr[ADDR_WIDTH+1:2] for RAM, addr[17:2] for decode.
- wdata  in  32  CPU write data.
- rdata  out  32  CPU read data, registered.
- rvalid  out  1  high the cycle after an accepted read.
- err  out  1  one-cycle pulse: access to unmapped word.
- vga_ren  in  1  VGA read enable.
- vga_raddr  in  32  VGA byte address.
- vga_rdata  out  32  VGA read data, registered.
- btn_in  in  BTN_WIDTH  asynchronous button levels.

Behaviour:
- Reset values:
  - rdata = 0, rvalid = 0, err = 0, vga_rdata = 0.
  - BTN_RAW = 0, BTN_EDGE = 0, CYCLE = 0.
  - RAM contents not reset.
- Decode on word index w = addr[17:2]:
  - RAM if w < 2**ADDR_WIDTH.
  - BTN_RAW at MMIO_BASE+0.
  - BTN_EDGE at MMIO_BASE+1.
  - CYCLE at MMIO_BASE+2.
  - Anything else is unmapped.
- CPU write (en & we):
  - Each lane with sel[i]=1 is written at the clock edge; other lanes unchanged.
  - rvalid stays 0; rdata holds its previous value.
- CPU read (en & ~we):
  - rdata loads the decoded word at the edge; rvalid = 1 for exactly that next cycle.
  - Back-to-back reads give one result per cycle.
  - sel is ignored for reads (full word returned).
- en = 0: no access, rvalid = 0, rdata holds.
- Unmapped access:
  - read returns rdata = 0 with rvalid = 1;
  - write is dropped;
  - err = 1 for one cycle in both cases.
- VGA port:
  - vga_ren = 1 -> vga_rdata = RAM[vga_raddr[ADDR_WIDTH+1:2]] next cycle; else vga_rdata holds.
  - Never sees MMIO; higher address bits are ignored (wrap).
- BTN_RAW:
  - two-flop synchroniser on btn_in; read-only, writes ignored.
- BTN_EDGE:
  - bit i set when synchronised bit goes 0->1; sticky.
  - CPU write clears bits where wdata=1 and the corresponding byte lane is selected (W1C).
  - Set and clear of the same bit in the same cycle: set wins.
- CYCLE:
  - +1 every cycle, wraps 0xFFFFFFFF -> 0.
  - A full-word write (sel=4'b1111) loads wdata, and incrementing resumes the following cycle.
  - Partial-sel writes are ignored.
- Read-during-write to the same RAM word on the CPU port cannot occur (single port).
- VGA read of the word the CPU writes in the same cycle: see Optional Feature.
- rst mid-operation: pending rvalid forced to 0 next cycle; any write in the reset cycle is still performed to RAM; MMIO regs reset.

Optional Feature:
- DATA_RAM_WRITE_FIRST_EN defined: VGA read colliding with a CPU RAM write returns the merged new data (selected lanes from wdata, others old).
- Undefined: the collision returns the old word (read-first).

Decomposition:
- Package data_ram_pkg holds:
  - MMIO offset constants (OFF_BTN_RAW=0, OFF_BTN_EDGE=1, OFF_CYCLE=2);
  - the byte-lane count (4);
  - the decode enum (DEC_RAM, DEC_BTN_RAW, DEC_BTN_EDGE, DEC_CYCLE, DEC_NONE).
- One sub-module, btn_sync_edge: synchroniser, edge detect and W1C sticky latch, BTN_WIDTH parametrised.

Test Plan:
- Byte writes: word 5 written 0xAABBCCDD with sel=1111, then 0x11223344 with sel=0101 -> read of word 5 gives rdata=0xAA22CC44, rvalid high exactly one cycle after the read.
- Back-to-back reads: reads of words 0,1,2 on consecutive cycles -> three consecutive rvalid pulses with matching data.
- Buttons: btn_in[3] 0->1 -> BTN_RAW bit3 = 1 two cycles later, BTN_EDGE = 0x8. Then write 0x8 to BTN_EDGE -> reads 0. Then W1C coincident with a new btn_in[3] edge -> still reads 0x8.
- CYCLE: write 0xFFFFFFFE with sel=1111 -> reads on the next two cycles return 0xFFFFFFFF then 0x00000000. A write with sel=0011 leaves the count running.
- Unmapped and VGA wrap: read of word MMIO_BASE+7 -> rdata=0, rvalid=1, err pulse. VGA read at byte address 0x1014 with ADDR_WIDTH=10 -> returns word 5.
- Collision and reset: VGA read coinciding with a CPU write 0xDEADBEEF to word 9 -> vga_rdata = old value (macro off) or 0xDEADBEEF (macro on). rst asserted during a read -> rvalid = 0, CYCLE = 0 the next cycle.
